csr_regfile: RTL and testbench
==============================

Name: csr_regfile

Overview:
- Machine-mode CSR register file that holds mstatus, mie, mtvec, mepc, mcause and mip, and drives them to the interrupt-decision logic.
- Executes Zicsr instructions from the pipeline CSR stage and samples the asynchronous timer/external interrupt lines into mip.
- Performs the state updates for trap entry and mret.
- Sits directly upstream of the interrupt/redirect combinational block; its register outputs are that block's inputs.

Parameters:
- DW, 32, data width of every CSR and of the PC.
- SYNC_STAGES, 2, flop stages in each interrupt-line synchroniser (legal values: 2 or 3).

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- csr_valid  input  1  CSR instruction present in the CSR stage this cycle.
- csr_op  input  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
- csr_addr  input  12  CSR address.
- csr_wdata  input  DW  rs1 value, or zero-extended uimm for the I variants.
- csr_rdata  output  DW  old CSR value, for rd writeback.
- illegal_csr  output  1  csr_valid with an unimplemented address or reserved csr_op.
- pc_in  input  DW  PC of the instruction being trapped.
- trap_take  input  1  pipeline commits interrupt entry this cycle.
- is_mret  input  1  mret commits this cycle.
- stall  input  1  CSR stage stalled; blocks all architectural updates.
- timer_irq_i  input  1  asynchronous machine timer interrupt line.
- ext_irq_i  input  1  asynchronous machine external interrupt line.
- mstatus_reg, mie_reg, mtvec_reg, mepc_reg, mcause_reg, mip_reg  output  DW each  current register values.

Behaviour:
- Addresses:
  - mstatus 0x300, mie 0x304, mtvec 0x305, mepc 0x341, mcause 0x342, mip 0x344.
  - Any other address: csr_rdata=0, illegal_csr=1 when csr_valid, no write.
- Reset values (async, on rst_n low):
  - mstatus=0x0000_1800 (MPP=2'b11); mie, mtvec, mepc, mcause, mip = 0.
  - Synchroniser flops = 0.
  - csr_rdata=0 and illegal_csr=0 (both combinational).
- Read: csr_rdata is the combinational pre-write value of the addressed CSR (0 when csr_valid=0). The write takes effect at the next clk edge.
- Write value:
  - RW: new = src. RS: new = old | src. RC: new = old & ~src.
  - RS/RC/RSI/RCI with src=0 leave the register unchanged and have no side effects.
- Writable-bit masks (non-writable bits keep their reset value):
  - mstatus: MIE[3], MPIE[7] only; MPP hardwired 11.
  - mie: MTIE[7], MEIE[11] only.
  - mtvec: bit1 forced 0.
  - mepc: bits[1:0] forced 0.
  - mcause: all bits writable.
  - mip: read-only; writes are ignored, no illegal flag.
- mip sampling:
  - mip[7] = timer_irq_i and mip[11] = ext_irq_i, each after SYNC_STAGES flops.
  - Latency from line change to mip_reg change is SYNC_STAGES cycles.
  - Sampling continues during stall.
- Trap entry, when trap_take=1 and stall=0, all on one edge:
  - mepc <= pc_in & ~3.
  - mcause <= {1'b1, 31'd11} if mip[11]&mie[11], else {1'b1, 31'd7}; external has priority over timer.
  - MPIE <= MIE; MIE <= 0.
- mret, when is_mret=1 and stall=0: MIE <= MPIE; MPIE <= 1.
- Same-cycle priority: trap_take > is_mret > CSR write.
  - The lower-priority update is dropped entirely; the pipeline flushes that instruction.
  - csr_rdata still reflects the old value.
- Stall: when stall=1, no CSR update of any kind. csr_rdata and illegal_csr remain valid.
- Reset mid-operation: an in-flight write or trap is lost; registers return to reset values immediately (asynchronous).

Optional Feature:
- Macro: CSR_MCYCLE_EN.
- Defined:
  - 64-bit mcycle counter, readable at 0xB00 (low word) and 0xB80 (high word), write-capable through CSR ops.
  - Increments every cycle, including during stall; the low-to-high carry wraps 0xFFFF_FFFF -> 0 with the high word incrementing.
  - A write to either half that cycle replaces that half's increment; the other half still increments with carry.
  - Reset value 0.
- Undefined: 0xB00 and 0xB80 decode as unimplemented (illegal_csr=1, rdata=0); no counter flops are present.

Decomposition:
- Package csr_pkg:
  - CSR address localparams and bit-index localparams (MIE, MPIE, MTIE, MEIE, MTIP, MEIP).
  - csr_op_e enum (funct3 encodings).
  - Cause codes CAUSE_MTI=7, CAUSE_MEI=11.
  - Per-register write masks.
- Sub-module irq_sync: SYNC_STAGES-deep, reset-to-0 synchroniser, instantiated once per interrupt line.

Test Plan:
- Reset then read 0x300 -> csr_rdata=0x0000_1800; all other CSR reads 0; csr_valid on 0x7C0 -> illegal_csr=1, rdata=0.
- RW 0x304 with 0xFFFF_FFFF -> mie_reg=0x0000_0880; then RC with 0x80 -> 0x800 and rdata=0x880; then RS with 0 -> no change.
- Raise timer_irq_i with MIE=1, MTIE=1 -> mip_reg[7] high exactly 2 cycles later; trap_take with pc_in=0x104 -> mepc=0x104, mcause=0x8000_0007, mstatus MIE=0, MPIE=1.
- Both irq lines high with both enables set, then trap_take -> mcause=0x8000_000B; is_mret next -> MIE=1, MPIE=1.
- trap_take with a same-cycle RW 0x341 of 0xDEAD_BEEF -> mepc=pc_in, write dropped; the same with stall=1 -> no register changes.
- With CSR_MCYCLE_EN: write 0xB00=0xFFFF_FFFE, run 3 cycles -> high word=1, low word=1.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared CSR addresses, bit positions, op encodings, cause codes and write masks.
// Latency: none (definitions only).
// Backpressure: n/a.
package csr_pkg;

  // Implemented CSR addresses
  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE  = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH = 12'hB80;

  // Bit positions inside mstatus / mie / mip
  localparam int BIT_MIE  = 3;
  localparam int BIT_MPIE = 7;
  localparam int BIT_MTIE = 7;
  localparam int BIT_MEIE = 11;
  localparam int BIT_MTIP = 7;
  localparam int BIT_MEIP = 11;

  // Zicsr funct3 encodings; 000 and 100 are reserved
  typedef enum logic [2:0] {
    OP_RW  = 3'b001,
    OP_RS  = 3'b010,
    OP_RC  = 3'b011,
    OP_RWI = 3'b101,
    OP_RSI = 3'b110,
    OP_RCI = 3'b111
  } csr_op_e;

  // Interrupt cause codes (interrupt bit added at the MSB)
  localparam int CAUSE_MTI = 7;
  localparam int CAUSE_MEI = 11;

  // Reset value and writable-bit masks; bits outside a mask keep their reset value
  localparam logic [31:0] MSTATUS_RST  = 32'h0000_1800;
  localparam logic [31:0] MASK_MSTATUS = 32'h0000_0088;
  localparam logic [31:0] MASK_MIE     = 32'h0000_0880;
  localparam logic [31:0] MASK_MTVEC   = 32'hFFFF_FFFD;
  localparam logic [31:0] MASK_MEPC    = 32'hFFFF_FFFC;
  localparam logic [31:0] MASK_MCAUSE  = 32'hFFFF_FFFF;

endpackage

// File: rtl/irq_sync.sv
// Multi-flop synchroniser for one asynchronous interrupt line, resets to 0.
// Latency: STAGES clk cycles from input change to output change.
// Backpressure: none; samples every cycle regardless of pipeline stalls.
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw line through the synchroniser chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], async_in};
  end

  assign sync_out = sync_q[STAGES-1];

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR file: Zicsr access, mip sampling, trap entry and mret updates.
// Latency: reads combinational (pre-write value); writes/trap/mret land on next clk edge.
// Backpressure: stall blocks every architectural update; optional CSR_MCYCLE_EN adds mcycle.
module csr_regfile
  import csr_pkg::*;
#(
  parameter int DW          = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          csr_valid,
  input  logic [2:0]    csr_op,
  input  logic [11:0]   csr_addr,
  input  logic [DW-1:0] csr_wdata,
  output logic [DW-1:0] csr_rdata,
  output logic          illegal_csr,
  input  logic [DW-1:0] pc_in,
  input  logic          trap_take,
  input  logic          is_mret,
  input  logic          stall,
  input  logic          timer_irq_i,
  input  logic          ext_irq_i,
  output logic [DW-1:0] mstatus_reg,
  output logic [DW-1:0] mie_reg,
  output logic [DW-1:0] mtvec_reg,
  output logic [DW-1:0] mepc_reg,
  output logic [DW-1:0] mcause_reg,
  output logic [DW-1:0] mip_reg
);

  logic          timer_sync;
  logic          ext_sync;
  logic          addr_ok;
  logic          op_ok;
  logic          is_rw;
  logic          wr_en;
  logic [DW-1:0] old_val;
  logic [DW-1:0] new_val;

`ifdef CSR_MCYCLE_EN
  logic [DW-1:0] mcycle_lo;
  logic [DW-1:0] mcycle_hi;
`endif

  irq_sync #(.STAGES(SYNC_STAGES)) u_sync_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (timer_irq_i),
    .sync_out (timer_sync)
  );

  irq_sync #(.STAGES(SYNC_STAGES)) u_sync_ext (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (ext_irq_i),
    .sync_out (ext_sync)
  );

  // mip is just the synchronised lines placed at their architectural bits
  always_comb begin
    mip_reg           = '0;
    mip_reg[BIT_MTIP] = timer_sync;
    mip_reg[BIT_MEIP] = ext_sync;
  end

  // Address decode and pre-write value of the addressed CSR
  always_comb begin
    addr_ok = 1'b1;
    old_val = '0;
    case (csr_addr)
      ADDR_MSTATUS: old_val = mstatus_reg;
      ADDR_MIE:     old_val = mie_reg;
      ADDR_MTVEC:   old_val = mtvec_reg;
      ADDR_MEPC:    old_val = mepc_reg;
      ADDR_MCAUSE:  old_val = mcause_reg;
      ADDR_MIP:     old_val = mip_reg;
`ifdef CSR_MCYCLE_EN
      ADDR_MCYCLE:  old_val = mcycle_lo;
      ADDR_MCYCLEH: old_val = mcycle_hi;
`endif
      default:      addr_ok = 1'b0;
    endcase
  end

  // Op decode and read-modify-write value; set/clear with a zero source never writes
  always_comb begin
    op_ok   = 1'b1;
    is_rw   = 1'b0;
    new_val = old_val;
    case (csr_op_e'(csr_op))
      OP_RW, OP_RWI: begin
        is_rw   = 1'b1;
        new_val = csr_wdata;
      end
      OP_RS, OP_RSI: new_val = old_val | csr_wdata;
      OP_RC, OP_RCI: new_val = old_val & ~csr_wdata;
      default:       op_ok = 1'b0;
    endcase
  end

  assign illegal_csr = csr_valid & ~(addr_ok & op_ok);
  assign csr_rdata   = (csr_valid && addr_ok) ? old_val : '0;
  assign wr_en       = csr_valid & addr_ok & op_ok & ~stall & ~trap_take & ~is_mret
                     & (is_rw | (csr_wdata != '0));

  // Architectural updates: trap entry beats mret beats CSR write, all frozen by stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_reg <= DW'(MSTATUS_RST);
      mie_reg     <= '0;
      mtvec_reg   <= '0;
      mepc_reg    <= '0;
      mcause_reg  <= '0;
    end else if (!stall) begin
      if (trap_take) begin
        mepc_reg              <= pc_in & ~DW'(3);
        mcause_reg            <= (mip_reg[BIT_MEIP] && mie_reg[BIT_MEIE])
                                 ? {1'b1, (DW-1)'(CAUSE_MEI)}
                                 : {1'b1, (DW-1)'(CAUSE_MTI)};
        mstatus_reg[BIT_MPIE] <= mstatus_reg[BIT_MIE];
        mstatus_reg[BIT_MIE]  <= 1'b0;
      end else if (is_mret) begin
        mstatus_reg[BIT_MIE]  <= mstatus_reg[BIT_MPIE];
        mstatus_reg[BIT_MPIE] <= 1'b1;
      end else if (wr_en) begin
        case (csr_addr)
          ADDR_MSTATUS: mstatus_reg <= (mstatus_reg & ~DW'(MASK_MSTATUS)) | (new_val & DW'(MASK_MSTATUS));
          ADDR_MIE:     mie_reg     <= (mie_reg & ~DW'(MASK_MIE)) | (new_val & DW'(MASK_MIE));
          ADDR_MTVEC:   mtvec_reg   <= new_val & DW'(MASK_MTVEC);
          ADDR_MEPC:    mepc_reg    <= new_val & DW'(MASK_MEPC);
          ADDR_MCAUSE:  mcause_reg  <= new_val & DW'(MASK_MCAUSE);
          default:      ;
        endcase
      end
    end
  end

`ifdef CSR_MCYCLE_EN
  // Free-running 64-bit cycle count; a write to one half replaces only that half's increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle_lo <= '0;
      mcycle_hi <= '0;
    end else begin
      mcycle_lo <= (wr_en && csr_addr == ADDR_MCYCLE)  ? new_val : mcycle_lo + 1'b1;
      mcycle_hi <= (wr_en && csr_addr == ADDR_MCYCLEH) ? new_val
                                                       : mcycle_hi + DW'(&mcycle_lo);
    end
  end
`endif

endmodule

// File: tb/tb_csr_regfile.sv
module tb_csr_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csr_valid;
  logic [2:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        illegal_csr;
  logic [31:0] pc_in;
  logic        trap_take;
  logic        is_mret;
  logic        stall;
  logic        timer_irq_i;
  logic        ext_irq_i;
  logic [31:0] mstatus_reg, mie_reg, mtvec_reg, mepc_reg, mcause_reg, mip_reg;

  int tests  = 0;
  int failed = 0;

  csr_regfile #(.DW(32), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .csr_valid   (csr_valid),
    .csr_op      (csr_op),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .csr_rdata   (csr_rdata),
    .illegal_csr (illegal_csr),
    .pc_in       (pc_in),
    .trap_take   (trap_take),
    .is_mret     (is_mret),
    .stall       (stall),
    .timer_irq_i (timer_irq_i),
    .ext_irq_i   (ext_irq_i),
    .mstatus_reg (mstatus_reg),
    .mie_reg     (mie_reg),
    .mtvec_reg   (mtvec_reg),
    .mepc_reg    (mepc_reg),
    .mcause_reg  (mcause_reg),
    .mip_reg     (mip_reg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are then driven 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr(input logic v, input logic [2:0] op, input logic [11:0] a, input logic [31:0] d);
    csr_valid = v;
    csr_op    = op;
    csr_addr  = a;
    csr_wdata = d;
  endtask

  logic [11:0] zero_addrs [5] = '{12'h304, 12'h305, 12'h341, 12'h342, 12'h344};

  initial begin
    rst_n = 1'b0; csr(1'b0, 3'b000, 12'h000, 32'h0);
    pc_in = 32'h0; trap_take = 1'b0; is_mret = 1'b0; stall = 1'b0;
    timer_irq_i = 1'b0; ext_irq_i = 1'b0;
    #12;
    check("rst_mstatus", mstatus_reg, 32'h0000_1800);
    check("rst_mie", mie_reg, 32'h0);
    check("rst_mepc", mepc_reg, 32'h0);
    check("rst_mcause", mcause_reg, 32'h0);
    check("rst_mip", mip_reg, 32'h0);
    check("rst_rdata", csr_rdata, 32'h0);
    check("rst_illegal", {31'h0, illegal_csr}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Reads (RS with zero source never writes)
    csr(1'b1, 3'b010, 12'h300, 32'h0); #1;
    check("rd_mstatus", csr_rdata, 32'h0000_1800);
    check("rd_mstatus_legal", {31'h0, illegal_csr}, 32'h0);
    foreach (zero_addrs[i]) begin
      csr_addr = zero_addrs[i]; #1;
      check("rd_zero", csr_rdata, 32'h0);
    end
    csr_addr = 12'h7C0; #1;
    check("rd_7c0_illegal", {31'h0, illegal_csr}, 32'h1);
    check("rd_7c0_rdata", csr_rdata, 32'h0);
    csr_op = 3'b000; csr_addr = 12'h300; #1;
    check("reserved_op_illegal", {31'h0, illegal_csr}, 32'h1);
    tick();

    // mie masks, clear, zero-source set
    csr(1'b1, 3'b001, 12'h304, 32'hFFFF_FFFF); #1;
    check("mie_rw_rdata", csr_rdata, 32'h0);
    tick();
    check("mie_rw", mie_reg, 32'h0000_0880);
    csr(1'b1, 3'b011, 12'h304, 32'h80); #1;
    check("mie_rc_rdata", csr_rdata, 32'h0000_0880);
    tick();
    check("mie_rc", mie_reg, 32'h0000_0800);
    csr(1'b1, 3'b010, 12'h304, 32'h0);
    tick();
    check("mie_rs0", mie_reg, 32'h0000_0800);

    // Other masks
    csr(1'b1, 3'b001, 12'h300, 32'hFFFF_FFFF); tick();
    check("mstatus_mask", mstatus_reg, 32'h0000_1888);
    csr(1'b1, 3'b001, 12'h305, 32'hFFFF_FFFF); tick();
    check("mtvec_mask", mtvec_reg, 32'hFFFF_FFFD);
    csr(1'b1, 3'b001, 12'h341, 32'h0000_1237); tick();
    check("mepc_mask", mepc_reg, 32'h0000_1234);
    csr(1'b1, 3'b101, 12'h342, 32'h5); tick();
    check("mcause_rwi", mcause_reg, 32'h5);
    csr(1'b1, 3'b001, 12'h344, 32'hFFFF_FFFF); #1;
    check("mip_wr_legal", {31'h0, illegal_csr}, 32'h0);
    tick();
    check("mip_ro", mip_reg, 32'h0);
    csr(1'b1, 3'b110, 12'h304, 32'h80); tick();
    check("mie_rsi", mie_reg, 32'h0000_0880);
    csr(1'b1, 3'b111, 12'h300, 32'h80); tick();
    check("mstatus_rci", mstatus_reg, 32'h0000_1808);
    csr(1'b0, 3'b000, 12'h000, 32'h0);

    // Timer line: visible in mip exactly 2 edges later
    timer_irq_i = 1'b1;
    tick();
    check("mip_lat1", mip_reg, 32'h0);
    tick();
    check("mip_lat2", mip_reg, 32'h80);

    // Timer trap
    trap_take = 1'b1; pc_in = 32'h104; tick();
    trap_take = 1'b0;
    check("trap_t_mepc", mepc_reg, 32'h104);
    check("trap_t_mcause", mcause_reg, 32'h8000_0007);
    check("trap_t_mstatus", mstatus_reg, 32'h0000_1880);

    // mret restores MIE=1
    is_mret = 1'b1; tick(); is_mret = 1'b0;
    check("mret1_mstatus", mstatus_reg, 32'h0000_1888);

    // External line, then trap with both pending: external wins
    ext_irq_i = 1'b1; tick(); tick();
    check("mip_both", mip_reg, 32'h880);
    trap_take = 1'b1; pc_in = 32'h203; tick(); trap_take = 1'b0;
    check("trap_e_mepc", mepc_reg, 32'h200);
    check("trap_e_mcause", mcause_reg, 32'h8000_000B);
    check("trap_e_mstatus", mstatus_reg, 32'h0000_1880);
    is_mret = 1'b1; tick(); is_mret = 1'b0;
    check("mret2_mstatus", mstatus_reg, 32'h0000_1888);

    // Trap beats a same-cycle CSR write
    trap_take = 1'b1; pc_in = 32'h308; csr(1'b1, 3'b001, 12'h341, 32'hDEAD_BEEF); #1;
    check("trap_wr_rdata", csr_rdata, 32'h200);
    tick();
    check("trap_wr_mepc", mepc_reg, 32'h308);
    check("trap_wr_mstatus", mstatus_reg, 32'h0000_1880);

    // Stall freezes everything; reads stay valid
    stall = 1'b1; pc_in = 32'h400; #1;
    check("stall_rdata", csr_rdata, 32'h308);
    tick();
    check("stall_mepc", mepc_reg, 32'h308);
    check("stall_mstatus", mstatus_reg, 32'h0000_1880);
    trap_take = 1'b0; is_mret = 1'b1; tick();
    check("stall_mret", mstatus_reg, 32'h0000_1880);
    stall = 1'b0;

    // mret beats a same-cycle CSR write
    csr(1'b1, 3'b001, 12'h342, 32'h5); tick(); is_mret = 1'b0;
    check("mret_wr_mcause", mcause_reg, 32'h8000_000B);
    check("mret_wr_mstatus", mstatus_reg, 32'h0000_1888);

`ifdef CSR_MCYCLE_EN
    csr(1'b1, 3'b001, 12'hB00, 32'hFFFF_FFFE); tick();
    csr(1'b0, 3'b000, 12'h000, 32'h0);
    tick(); tick(); tick();
    csr(1'b1, 3'b010, 12'hB00, 32'h0); #1;
    check("mcycle_lo", csr_rdata, 32'h1);
    csr_addr = 12'hB80; #1;
    check("mcycle_hi", csr_rdata, 32'h1);
`else
    csr(1'b1, 3'b010, 12'hB00, 32'h0); #1;
    check("mcycle_absent_illegal", {31'h0, illegal_csr}, 32'h1);
    check("mcycle_absent_rdata", csr_rdata, 32'h0);
`endif

    // Asynchronous reset mid-write
    csr(1'b1, 3'b001, 12'h304, 32'h0);
    rst_n = 1'b0; #1;
    check("arst_mie", mie_reg, 32'h0);
    check("arst_mstatus", mstatus_reg, 32'h0000_1800);
    check("arst_mepc", mepc_reg, 32'h0);
    check("arst_mip", mip_reg, 32'h0);
    csr(1'b0, 3'b000, 12'h000, 32'h0);
    #3 rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
